issue_scoreboard: RTL and testbench

- Scoreboard and issue controller between the decode stage and the execute/memory units.
- Tracks which architectural registers have a result still outstanding, and detects RAW, WAW and memory-unit structural hazards for the instruction currently held in decode.
- Drives the issue stall (is_if_stall) that freezes the decode pipeline register. Counts stall cycles for performance monitoring.

---
 rtl/issue_scoreboard.sv | 103 ++++++++++
 tb/tb_issue_scoreboard.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Scoreboard and issue controller between decode and the execute/memory units.
// Tracks outstanding register writes, detects RAW/WAW/memory hazards, and counts stall cycles.
module issue_scoreboard #(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_addra,
  input  logic [4:0]       id_addrb,
  input  logic [1:0]       id_numop,
  input  logic             id_writereg,
  input  logic [4:0]       id_regdest,
  input  logic             id_readmem,
  input  logic             id_writemem,
  input  logic             wb_writereg,
  input  logic [4:0]       wb_regdest,
  input  logic             flush,
  output logic             is_if_stall,
  output logic             issue_fire,
  output logic [31:0]      busy_vec,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [3:0]       MEM_LAT_V = 4'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [31:0]      r_busy;
  logic [3:0]       r_mem_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [31:0] w_eff_busy;
  logic [31:0] w_busy_next;
  logic        w_raw_a;
  logic        w_raw_b;
  logic        w_waw;
  logic        w_mem_op;
  logic        w_struct;
  logic        w_stall;
  logic        w_fire;
  logic        w_set_en;

  // A same-cycle writeback releases its register before any hazard check;
  // a same-cycle issue to that register re-marks it, so set wins over clear.
  for (genvar gi = 0; gi < 32; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign w_eff_busy[gi]  = 1'b0;
      assign w_busy_next[gi] = 1'b0;
    end else begin : g_busy
      logic w_wb_hit;
      logic w_set_hit;
      assign w_wb_hit        = wb_writereg && (wb_regdest == 5'(gi));
      assign w_set_hit       = w_set_en && (id_regdest == 5'(gi));
      assign w_eff_busy[gi]  = r_busy[gi] && !w_wb_hit;
      assign w_busy_next[gi] = w_eff_busy[gi] || w_set_hit;
    end
  end

  assign w_raw_a  = (id_numop != 2'd0) && (id_addra != 5'd0) && w_eff_busy[id_addra];
  assign w_raw_b  = id_numop[1] && (id_addrb != 5'd0) && w_eff_busy[id_addrb];
  assign w_waw    = id_writereg && (id_regdest != 5'd0) && w_eff_busy[id_regdest];
  assign w_mem_op = id_readmem || id_writemem;
  assign w_struct = w_mem_op && (r_mem_cnt != 4'd0);

  assign w_stall  = id_valid && (w_raw_a || w_raw_b || w_waw || w_struct) && !flush;
  assign w_fire   = id_valid && !w_stall && !flush;
  assign w_set_en = w_fire && id_writereg && (id_regdest != 5'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy    <= 32'd0;
      r_mem_cnt <= 4'd0;
    end else if (flush) begin
      r_busy    <= 32'd0;
      r_mem_cnt <= 4'd0;
    end else begin
      r_busy <= w_busy_next;
      if (w_fire && w_mem_op) begin
        r_mem_cnt <= MEM_LAT_V;
      end else if (r_mem_cnt != 4'd0) begin
        r_mem_cnt <= r_mem_cnt - 4'd1;
      end
    end
  end

  // The performance counter survives pipeline flushes; only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign is_if_stall = w_stall;
  assign issue_fire  = w_fire;
  assign busy_vec    = r_busy;
  assign mem_busy    = (r_mem_cnt != 4'd0);
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed steps followed by random traffic,
// each cycle compared with a per-register pending-write model.
module tb_issue_scoreboard;

  localparam int MEM_LAT = 3;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = 65535;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             id_valid = 1'b0;
  logic [4:0]       id_addra = '0;
  logic [4:0]       id_addrb = '0;
  logic [1:0]       id_numop = '0;
  logic             id_writereg = 1'b0;
  logic [4:0]       id_regdest = '0;
  logic             id_readmem = 1'b0;
  logic             id_writemem = 1'b0;
  logic             wb_writereg = 1'b0;
  logic [4:0]       wb_regdest = '0;
  logic             flush = 1'b0;
  logic             is_if_stall;
  logic             issue_fire;
  logic [31:0]      busy_vec;
  logic             mem_busy;
  logic [CNT_W-1:0] stall_count;

  issue_scoreboard #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_addra(id_addra), .id_addrb(id_addrb),
    .id_numop(id_numop), .id_writereg(id_writereg), .id_regdest(id_regdest),
    .id_readmem(id_readmem), .id_writemem(id_writemem),
    .wb_writereg(wb_writereg), .wb_regdest(wb_regdest), .flush(flush),
    .is_if_stall(is_if_stall), .issue_fire(issue_fire), .busy_vec(busy_vec),
    .mem_busy(mem_busy), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Reference state: which registers await a result, memory cycles left, stall total.
  bit pend[32];
  int memc = 0;
  int scnt = 0;
  bit last_fire = 1'b0;
  int mbc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = pend[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    memc = 0;
  endtask

  task automatic instr(input bit v, input int a, input int b, input int nop,
                       input bit wr, input int rd, input bit ld, input bit st);
    id_valid = v; id_addra = 5'(a); id_addrb = 5'(b); id_numop = 2'(nop);
    id_writereg = wr; id_regdest = 5'(rd); id_readmem = ld; id_writemem = st;
  endtask

  task automatic wb(input bit w, input int d);
    wb_writereg = w; wb_regdest = 5'(d);
  endtask

  // Called with the clock low: predicts, checks, clocks once, advances the model.
  task automatic cycle(input string tag);
    bit eff[32];
    bit hz;
    bit memop;
    bit m_stall;
    bit m_fire;
    eff = pend;
    if (wb_writereg) eff[wb_regdest] = 1'b0;
    hz = 1'b0;
    if (id_numop >= 1 && id_addra != 0 && eff[id_addra]) hz = 1'b1;
    if (id_numop >= 2 && id_addrb != 0 && eff[id_addrb]) hz = 1'b1;
    if (id_writereg && id_regdest != 0 && eff[id_regdest]) hz = 1'b1;
    memop = id_readmem || id_writemem;
    if (memop && memc != 0) hz = 1'b1;
    m_stall = id_valid && hz && !flush;
    m_fire  = id_valid && !m_stall && !flush;
    #1;
    chk({tag, ".stall"}, 32'(is_if_stall), 32'(m_stall));
    chk({tag, ".fire"},  32'(issue_fire),  32'(m_fire));
    chk({tag, ".busy"},  busy_vec,         pend_vec());
    chk({tag, ".mem"},   32'(mem_busy),    32'(memc != 0));
    chk({tag, ".cnt"},   32'(stall_count), 32'(scnt));
    if (mem_busy) mbc++;
    @(posedge clock);
    if (flush) begin
      model_clear();
    end else begin
      pend = eff;
      if (m_fire && id_writereg && id_regdest != 0) pend[id_regdest] = 1'b1;
      if (m_fire && memop) memc = MEM_LAT;
      else if (memc > 0) memc--;
    end
    if (m_stall && scnt < CNT_MAX) scnt++;
    last_fire = m_fire;
    @(negedge clock);
  endtask

  initial begin
    int k;
    int sc_before;
    model_clear();
    #3;
    chk("reset.busy", busy_vec, 32'h0);
    chk("reset.mem", 32'(mem_busy), 32'h0);
    chk("reset.cnt", 32'(stall_count), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // add r3 <- r1, r2
    instr(1, 1, 2, 2, 1, 3, 0, 0);
    cycle("add");
    #1 chk("add.busy_r3", busy_vec, 32'h0000_0008);

    // read r3 as B while busy, then release it by a same-cycle writeback
    instr(1, 4, 3, 2, 1, 6, 0, 0);
    repeat (3) cycle("raw");
    wb(1, 3);
    cycle("raw_wb");
    chk("raw_wb.fired", 32'(last_fire), 32'h1);
    wb(0, 0);
    instr(1, 0, 0, 0, 1, 3, 0, 0);
    cycle("set_r3");
    wb(1, 3);
    cycle("wb_and_set_r3");
    wb(0, 0);
    #1 chk("set_wins.r3", 32'(busy_vec[3]), 32'h1);

    // WAW on r5, then flush and check r0 never marks or stalls
    instr(1, 0, 0, 0, 1, 5, 0, 0);
    cycle("set_r5");
    repeat (2) cycle("waw_r5");
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    cycle("clr");
    flush = 1'b0;
    instr(1, 0, 0, 1, 1, 0, 0, 0);
    repeat (2) cycle("r0");

    // load then back-to-back store: structural spacing
    instr(1, 1, 0, 1, 1, 9, 1, 0);
    cycle("load");
    mbc = 0;
    instr(1, 2, 4, 2, 0, 0, 0, 1);
    k = 0;
    cycle("store");
    while (!last_fire && k < 10) begin
      k++;
      cycle("store");
    end
    chk("store.wait", 32'(k), 32'd3);
    chk("store.membusy_cycles", 32'(mbc), 32'd3);

    // r7 busy with memory counter at 2, then flush
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) cycle("idle");
    instr(1, 0, 0, 0, 1, 7, 1, 0);
    cycle("ld_r7");
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("idle2");
    sc_before = scnt;
    instr(1, 0, 0, 0, 1, 10, 0, 0);
    flush = 1'b1;
    cycle("flush");
    chk("flush.nofire", 32'(last_fire), 32'h0);
    flush = 1'b0;
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("flush.busy", busy_vec, 32'h0);
    chk("flush.mem", 32'(mem_busy), 32'h0);
    chk("flush.cnt", 32'(stall_count), 32'(sc_before));

    // random traffic on a small register window so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      instr($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      wb($urandom_range(0, 1), $urandom_range(0, 7));
      flush = ($urandom_range(0, 39) == 0);
      cycle("rnd");
    end
    flush = 1'b0;
    wb(0, 0);

    // saturate the stall counter on a persistent WAW
    instr(1, 0, 0, 0, 1, 5, 0, 0);
    cycle("sat_set");
    cycle("sat_stall");
    repeat (65540) @(posedge clock);
    scnt = (scnt + 65540 > CNT_MAX) ? CNT_MAX : scnt + 65540;
    @(negedge clock);
    #1 chk("sat.cnt", 32'(stall_count), 32'h0000_FFFF);
    chk("sat.stall", 32'(is_if_stall), 32'h1);

    // asynchronous reset mid-stall
    #1 reset = 1'b0;
    #1;
    chk("areset.cnt", 32'(stall_count), 32'h0);
    chk("areset.busy", busy_vec, 32'h0);
    chk("areset.mem", 32'(mem_busy), 32'h0);
    chk("areset.fire", 32'(issue_fire), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
